// File: rtl/alu_mdu.sv
// alu_mdu: registered RV32I ALU with an optional iterative M-extension unit.
// Base ops and divide special cases finish in one cycle. MUL*/DIV*/REM*
// iterate for XLEN cycles in CALC before the result is published in DONE.
module alu_mdu #(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            alu_imm,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [XLEN-1:0] imm,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);
   localparam int SW = $clog2(XLEN);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [SW-1:0]   CNT_LAST = SW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]        state_q, state_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [SW-1:0]     cnt_q, cnt_d;
   // Multiply: {partial product high, multiplier shifting out}.
   // Divide:   {partial remainder, dividend shifting into quotient}.
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
   logic              div_q, div_d;     // 1: divide, 0: multiply
   logic              hi_q, hi_d;       // high product half, or remainder
   logic              neg_q, neg_d;     // product / quotient sign
   logic              rneg_q, rneg_d;   // remainder sign

   logic                     accept, is_m, is_sub, iter_op;
   logic                     div_zero, div_ovf, a_sgn, b_sgn, sa, sb;
   logic [XLEN-1:0]          opb, base_res, fast_res, a_mag, b_mag;
   logic signed [XLEN-1:0]   sra_res;
   logic [SW-1:0]            shamt;
   logic [XLEN:0]            add_sum, shl_rem, sub_rem;
   logic [2*XLEN-1:0]        acc_step, prod_fix;
   logic [XLEN-1:0]          quo_fix, rem_fix, fin_res;

   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_CALC);
   assign result    = result_q;
   assign accept    = in_valid && in_ready;

   assign opb     = alu_imm ? imm : op_b;
   assign shamt   = opb[SW-1:0];
   assign is_m    = !alu_imm && (funct7 == 7'b0000001);
   assign is_sub  = !alu_imm && funct7[5];
   // kept separate so the arithmetic shift is not turned unsigned by a mux
   assign sra_res = $signed(op_a) >>> shamt;

   // single-cycle base ALU
   always_comb begin
      base_res = '0;
      case (funct3)
         3'b000:  base_res = is_sub ? (op_a - opb) : (op_a + opb);
         3'b001:  base_res = op_a << shamt;
         3'b010:  base_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(opb))};
         3'b011:  base_res = {{(XLEN-1){1'b0}}, (op_a < opb)};
         3'b100:  base_res = op_a ^ opb;
         3'b101:  base_res = funct7[5] ? sra_res : (op_a >> shamt);
         3'b110:  base_res = op_a | opb;
         default: base_res = op_a & opb;
      endcase
   end

   // M-op operand conditioning: magnitudes plus signs, and the divide special
   // cases that bypass the iterative datapath
   assign div_zero = (op_b == '0);
   assign div_ovf  = !funct3[0] && (op_a == MIN_NEG) && (&op_b);
   assign fast_res = div_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
   assign a_sgn    = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
   assign b_sgn    = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01);
   assign sa       = a_sgn & op_a[XLEN-1];
   assign sb       = b_sgn & op_b[XLEN-1];
   assign a_mag    = sa ? -op_a : op_a;
   assign b_mag    = sb ? -op_b : op_b;
   assign iter_op  = is_m && ENABLE_M && !(funct3[2] && (div_zero || div_ovf));

   // one shift-add or restoring-divide step per cycle
   assign add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign shl_rem  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign sub_rem  = shl_rem - {1'b0, opnd_q};
   assign acc_step = !div_q     ? {add_sum, acc_q[XLEN-1:1]} :
                     sub_rem[XLEN] ? {shl_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0} :
                                     {sub_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

   // sign restore on the final step's value, then half / quotient select
   assign prod_fix = neg_q  ? -acc_step : acc_step;
   assign quo_fix  = neg_q  ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
   assign rem_fix  = rneg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
   assign fin_res  = div_q ? (hi_q ? rem_fix : quo_fix)
                           : (hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0]);

   // FSM and datapath next state; an accept overrides the hold/drain path
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      div_d    = div_q;
      hi_d     = hi_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      case (state_q)
         S_CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q + SW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d  = S_DONE;
               result_d = fin_res;
               cnt_d    = '0;
            end
         end
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (accept) begin
         if (iter_op) begin
            state_d = S_CALC;
            cnt_d   = '0;
            div_d   = funct3[2];
            hi_d    = funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);
            neg_d   = sa ^ sb;
            rneg_d  = sa;
            acc_d   = {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
            opnd_d  = funct3[2] ? b_mag : a_mag;
         end else begin
            state_d  = S_DONE;
            result_d = is_m ? (ENABLE_M ? fast_res : '0) : base_res;
         end
      end
   end

   // state registers; reset drops any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         div_q    <= 1'b0;
         hi_q     <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         div_q    <= div_d;
         hi_q     <= hi_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
      end
   end
endmodule
